// File: rtl/f_pc_ctrl.sv
// Fetch-stage program-counter controller.
// Selects the next PC by priority, defers stalled redirects, flags AdEL and counts fetches.
module f_pc_ctrl #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [PC_W-1:0] EXC_PC   = 32'h0000_4180,
  parameter logic [PC_W-1:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [PC_W-1:0] IMEM_HI  = 32'h0000_6FFC,
  parameter logic [PC_W-1:0] STEP     = 32'd4,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              stall_i,
  input  logic              br_valid_i,
  input  logic [PC_W-1:0]   br_target_i,
  input  logic              exc_req_i,
  input  logic              eret_req_i,
  input  logic [PC_W-1:0]   epc_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              adel_o,
  output logic              pend_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  // state | meaning
  // RUN   | no redirect outstanding
  // PEND  | redirect captured during stall, applied when stall releases
  typedef enum logic {RUN, PEND} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_we;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    pc_we   = 1'b0;
    if (exc_req_i) begin
      pc_d    = EXC_PC;
      state_d = RUN;
      pc_we   = 1'b1;
    end else if (eret_req_i) begin
      pc_d    = epc_i;
      state_d = RUN;
      pc_we   = 1'b1;
    end else if (br_valid_i && stall_i) begin
      tgt_d   = br_target_i;
      state_d = PEND;
    end else if (br_valid_i) begin
      pc_d    = br_target_i;
      state_d = RUN;
      pc_we   = 1'b1;
    end else if (state_q == PEND && !stall_i) begin
      pc_d    = tgt_q;
      state_d = RUN;
      pc_we   = 1'b1;
    end else if (!stall_i) begin
      pc_d    = pc_q + STEP;
      pc_we   = 1'b1;
    end
    // An equal-value rewrite still counts as a fetch.
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pc_we};
  end

  assign pc_o        = pc_q;
  assign pend_o      = (state_q == PEND);
  assign fetch_cnt_o = cnt_q;
  assign adel_o      = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Self-checking bench for f_pc_ctrl: spec-level model compared every cycle,
// plus literal checkpoints and a second instance with a 2-bit fetch counter.
module tb_f_pc_ctrl;

  logic        clk = 0;
  logic        rst_n;
  logic        stall, br_valid, exc_req, eret_req;
  logic [31:0] br_target, epc;
  logic [31:0] pc, pc2;
  logic        adel, adel2, pend, pend2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int n_chk = 0;
  int n_fail = 0;

  // model state, kept as plain integers
  longint unsigned m_pc, m_tgt, m_cnt;
  bit              m_pend;

  always #5 clk = ~clk;

  f_pc_ctrl dut (
    .clk_i(clk), .reset_n_i(rst_n), .stall_i(stall), .br_valid_i(br_valid),
    .br_target_i(br_target), .exc_req_i(exc_req), .eret_req_i(eret_req),
    .epc_i(epc), .pc_o(pc), .adel_o(adel), .pend_o(pend), .fetch_cnt_o(cnt)
  );

  f_pc_ctrl #(.CNT_W(2)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .stall_i(stall), .br_valid_i(br_valid),
    .br_target_i(br_target), .exc_req_i(exc_req), .eret_req_i(eret_req),
    .epc_i(epc), .pc_o(pc2), .adel_o(adel2), .pend_o(pend2), .fetch_cnt_o(cnt2)
  );

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_adel();
    return (m_pc % 4 != 0) || (m_pc < 64'h3000) || (m_pc > 64'h6FFC);
  endfunction

  task automatic m_reset();
    m_pc = 64'h3000; m_tgt = 0; m_cnt = 0; m_pend = 0;
  endtask

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("adel", adel, m_adel());
    chk("pend", pend, m_pend);
    chk("fetch_cnt", cnt, m_cnt % 65536);
    chk("pc_w2", pc2, m_pc);
    chk("fetch_cnt_w2", cnt2, m_cnt % 4);
  end

  // one clock edge with given inputs, then advance the model by the priority rules
  task automatic cyc(input bit s, input bit br, input logic [31:0] tgt,
                     input bit ex, input bit er, input logic [31:0] e);
    stall = s; br_valid = br; br_target = tgt; exc_req = ex; eret_req = er; epc = e;
    @(posedge clk);
    if (ex) begin
      m_pc = 64'h4180; m_pend = 0; m_cnt++;
    end else if (er) begin
      m_pc = e; m_pend = 0; m_cnt++;
    end else if (br && s) begin
      m_tgt = tgt; m_pend = 1;
    end else if (br) begin
      m_pc = tgt; m_pend = 0; m_cnt++;
    end else if (m_pend && !s) begin
      m_pc = m_tgt; m_pend = 0; m_cnt++;
    end else if (!s) begin
      m_pc = (m_pc + 4) % 64'h1_0000_0000; m_cnt++;
    end
    #1;
  endtask

  task automatic seq(); cyc(0, 0, 0, 0, 0, 0); endtask

  initial begin
    rst_n = 0; m_reset();
    stall = 0; br_valid = 0; br_target = 0; exc_req = 0; eret_req = 0; epc = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_pc", pc, 32'h3000);
    chk("reset_pend", pend, 0);
    chk("reset_cnt", cnt, 0);
    rst_n = 1;

    seq(); chk("seq1", pc, 32'h3004);
    seq(); chk("seq2", pc, 32'h3008);
    seq(); chk("seq3", pc, 32'h300C);
    chk("seq_cnt", cnt, 3);
    chk("seq_adel", adel, 0);

    seq();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("stall_hold", pc, 32'h3010);
    chk("stall_cnt", cnt, 4);
    seq(); chk("stall_release", pc, 32'h3014);

    cyc(1, 1, 32'h3400, 0, 0, 0);
    chk("pend_set", pend, 1);
    chk("pend_pc_held", pc, 32'h3014);
    cyc(1, 1, 32'h3500, 0, 0, 0);
    chk("pend_latest", pend, 1);
    seq();
    chk("pend_apply_pc", pc, 32'h3500);
    chk("pend_apply_clr", pend, 0);
    chk("pend_apply_cnt", cnt, 6);

    cyc(1, 1, 32'h3600, 0, 0, 0);
    cyc(1, 1, 32'h3700, 1, 0, 0);
    chk("exc_pc", pc, 32'h4180);
    chk("exc_pend", pend, 0);
    cyc(0, 0, 0, 0, 1, 32'h3020);
    chk("eret_pc", pc, 32'h3020);
    chk("eret_cnt", cnt, 8);

    cyc(0, 1, 32'h3002, 0, 0, 0); chk("adel_unaligned", adel, 1);
    cyc(0, 1, 32'h2FFC, 0, 0, 0); chk("adel_below", adel, 1);
    cyc(0, 1, 32'h7000, 0, 0, 0); chk("adel_above", adel, 1);
    cyc(0, 1, 32'h6FFC, 0, 0, 0); chk("adel_hi_edge", adel, 0);
    seq(); chk("adel_seq_over", adel, 1);
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    seq(); chk("pc_wrap", pc, 32'h0);
    // equal-value redirect still counts
    cyc(0, 1, 32'h0, 0, 0, 0); chk("eq_write_cnt", cnt, 16);

    // 2-bit counter wrap after fresh reset
    #2 rst_n = 0; m_reset(); #1;
    chk("rst2_cnt2", cnt2, 0);
    @(negedge clk); rst_n = 1; #1;
    seq(); chk("w2_c1", cnt2, 1);
    seq(); chk("w2_c2", cnt2, 2);
    seq(); chk("w2_c3", cnt2, 3);
    seq(); chk("w2_c4", cnt2, 0);
    seq(); chk("w2_c5", cnt2, 1);

    // reset mid-PEND
    cyc(1, 1, 32'h3800, 0, 0, 0);
    chk("midpend_set", pend, 1);
    #2 rst_n = 0; m_reset(); #1;
    chk("midpend_rst_pc", pc, 32'h3000);
    chk("midpend_rst_pend", pend, 0);
    @(negedge clk); rst_n = 1; #1;
    seq();
    chk("midpend_discard", pc, 32'h3004);

    repeat (2) seq();
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
